synth_note_fetcher: RTL and testbench
=====================================

// Module: synth_note_fetcher
// PURPOSE
//  Reads a note table from user data memory through the read-only synth port (port B) of the
//  dual-port user data block, and plays it one note at a time. The CPU writes the table on
//  port A; this block walks it word by word. It presents pitch/volume plus a gate to the synth.
// PARAMETERS
//  MAX_NOTES    256  table length limit in words; index width = $clog2(MAX_NOTES)
//  MEM_LATENCY  1    clocks from oSynthAddress change to valid iSynthNoteData (1..3)
// PORTS
//  iCLK            in   1   system clock; memory port B is clocked on the same edge domain
//  iRST            in   1   synchronous, active-high reset
//  iStart          in   1   pulse: begin playback at iBaseAddr (ignored while oBusy)
//  iStop           in   1   abort playback (level or pulse)
//  iLoop           in   1   sampled at end of table: 1 = restart at index 0
//  iTick           in   1   1-cycle duration strobe (e.g. 1 ms)
//  iBaseAddr       in   32  byte address of table, word aligned ([1:0] ignored)
//  oSynthAddress   out  32  byte address driven to memory port B
//  iSynthNoteData  in   32  note word: [31] rsvd, [30:24] volume, [23:16] pitch, [15:0] duration
//  oPitch          out  8   current note pitch
//  oVolume         out  7   current note volume
//  oNoteOn         out  1   gate: high while a note sounds
//  oBusy           out  1   high in any state except IDLE
//  oDone           out  1   1-cycle pulse when table ends without loop
// BEHAVIOUR
//  Reset: state IDLE, index 0, oSynthAddress = 0, oPitch = 0, oVolume = 0, oNoteOn = 0,
//   oBusy = 0, oDone = 0. iRST mid-playback takes effect on the next edge; no oDone pulse.
//  States: IDLE, ADDR, WAIT, DECODE, PLAY.
//   IDLE:   iStart && !iStop -> latch base = {iBaseAddr[31:2],2'b00}, index = 0, go to ADDR.
//   ADDR:   oSynthAddress = base + {index,2'b00} (32-bit add, carry discarded); load the wait
//           counter with MEM_LATENCY; go to WAIT.
//   WAIT:   decrement the counter; when it reaches 0, register iSynthNoteData and go to DECODE.
//   DECODE: duration == 0 is the end marker -> END. Otherwise load oPitch and oVolume, load
//           the duration counter, set oNoteOn = 1, go to PLAY.
//   PLAY:   each iTick decrements the counter. An iTick seen when the counter is 1 ends the
//           note: oNoteOn = 0 on the next edge. Then, if index == MAX_NOTES-1 -> END;
//           otherwise index++ and go to ADDR.
//   END:    a transition action, not a state. If iLoop = 1: index = 0, go to ADDR, no oDone.
//           If iLoop = 0: oDone = 1 for one cycle, go to IDLE.
//  oDone polarity: when the table ends, oDone pulses high for exactly one cycle.
//  iTick during ADDR, WAIT or DECODE is not counted. Inter-note gap is MEM_LATENCY+2 cycles
//   with oNoteOn low.
//  iStop has priority over everything except iRST. From any state it forces IDLE on the next
//   edge: oNoteOn = 0, oPitch and oVolume hold their last values, and no oDone pulse.
//  iStart && iStop in the same cycle: stop wins and the block stays in IDLE.
//  iStart while oBusy is ignored.
//  oSynthAddress holds its value outside ADDR. oPitch and oVolume change only in DECODE.
//  Duration 0xFFFF plays for 65535 ticks. There is no saturation and no other wrap.
// TESTING
//  1 Table @0x10010000 = {0x40450003, 0x20480001, 0x00000000}; iStart; iTick every 10 clk
//    -> pitch 0x45 vol 0x40 gate held 3 ticks, then 0x48 vol 0x20 for 1 tick, oDone pulse x1.
//  2 Table word0 = 0x00000000 -> oNoteOn never rises; oDone exactly MEM_LATENCY+3 clk after
//    iStart.
//  3 Same table as 1 with iLoop = 1 -> after the 2nd note, address returns to 0x10010000; no
//    oDone; after 3 loops assert iStop -> IDLE next cycle, oNoteOn = 0, no oDone.
//  4 MAX_NOTES = 4, four nonzero words and no marker -> last address 0x1001000C, then oDone;
//    address never reaches 0x10010010.
//  5 iRST mid-PLAY with oPitch = 0x45 -> next cycle oPitch = 0, oBusy = 0, oNoteOn = 0;
//    iStart && iStop together -> stays IDLE.
//  6 MEM_LATENCY = 2 with a port-B model delaying 2 clk -> same pitch sequence as test 1;
//    gap = 4 clk.

Source files
------------

// File: rtl/synth_note_fetcher_if.sv
// synth_note_fetcher_if: control, memory port B and synth-side signals of the note fetcher
interface synth_note_fetcher_if;
    logic        iStart;
    logic        iStop;
    logic        iLoop;
    logic        iTick;
    logic [31:0] iBaseAddr;
    logic [31:0] oSynthAddress;
    logic [31:0] iSynthNoteData;
    logic [7:0]  oPitch;
    logic [6:0]  oVolume;
    logic        oNoteOn;
    logic        oBusy;
    logic        oDone;
    modport slave (
        input  iStart, iStop, iLoop, iTick, iBaseAddr, iSynthNoteData,
        output oSynthAddress, oPitch, oVolume, oNoteOn, oBusy, oDone
    );
    modport master (
        output iStart, iStop, iLoop, iTick, iBaseAddr, iSynthNoteData,
        input  oSynthAddress, oPitch, oVolume, oNoteOn, oBusy, oDone
    );
endinterface

// File: rtl/synth_note_fetcher.sv
// synth_note_fetcher: walks a note table over memory port B and gates pitch/volume to the synth
module synth_note_fetcher #(
    parameter int MAX_NOTES   = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic                iCLK,
    input  logic                iRST,
    synth_note_fetcher_if.slave bus
);
    localparam int IW = $clog2(MAX_NOTES);
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, DECODE, PLAY} state_t;
    state_t        state, stateNext;
    logic [31:0]   base, synthAddress;
    logic [IW-1:0] index;
    logic [1:0]    waitCnt;
    logic [15:0]   durCnt, noteDur;
    logic [7:0]    notePitch, pitch;
    logic [6:0]    noteVol, volume;
    logic          noteOn, done;
    logic          noteEnd, lastIndex, tableEnd;
    assign noteEnd   = state == PLAY && bus.iTick && durCnt == 16'd1;
    assign lastIndex = index == IW'(MAX_NOTES - 1);
    assign tableEnd  = (state == DECODE && noteDur == 16'd0) || (noteEnd && lastIndex);
    assign bus.oSynthAddress = synthAddress;
    assign bus.oPitch        = pitch;
    assign bus.oVolume       = volume;
    assign bus.oNoteOn       = noteOn;
    assign bus.oBusy         = state != IDLE;
    assign bus.oDone         = done;
    // next state: stop beats everything, table end either loops or returns to IDLE
    always_comb begin
        stateNext = state;
        if (bus.iStop) stateNext = IDLE;
        else if (tableEnd) stateNext = bus.iLoop ? ADDR : IDLE;
        else case (state)
            IDLE:    stateNext = bus.iStart ? ADDR : IDLE;
            ADDR:    stateNext = WAIT;
            WAIT:    stateNext = waitCnt == 2'd1 ? DECODE : WAIT;
            DECODE:  stateNext = PLAY;
            PLAY:    stateNext = noteEnd ? ADDR : PLAY;
            default: stateNext = IDLE;
        endcase
    end
    // state register plus address, fetch, note and index datapath
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= IDLE;
            base         <= '0;
            synthAddress <= '0;
            index        <= '0;
            waitCnt      <= '0;
            durCnt       <= '0;
            noteDur      <= '0;
            notePitch    <= '0;
            noteVol      <= '0;
            pitch        <= '0;
            volume       <= '0;
            noteOn       <= 1'b0;
            done         <= 1'b0;
        end else begin
            state <= stateNext;
            done  <= !bus.iStop && tableEnd && !bus.iLoop;
            if (bus.iStop) noteOn <= 1'b0;
            else begin
                if (state == IDLE && bus.iStart) begin
                    base  <= {bus.iBaseAddr[31:2], 2'b00};
                    index <= '0;
                end
                if (state == ADDR) begin
                    synthAddress <= base + 32'({index, 2'b00});
                    waitCnt      <= 2'(MEM_LATENCY);
                end
                if (state == WAIT) begin
                    waitCnt <= waitCnt - 2'd1;
                    if (waitCnt == 2'd1) begin
                        noteVol   <= bus.iSynthNoteData[30:24];
                        notePitch <= bus.iSynthNoteData[23:16];
                        noteDur   <= bus.iSynthNoteData[15:0];
                    end
                end
                if (state == DECODE && noteDur != 16'd0) begin
                    pitch  <= notePitch;
                    volume <= noteVol;
                    durCnt <= noteDur;
                    noteOn <= 1'b1;
                end
                if (state == PLAY && bus.iTick) durCnt <= durCnt - 16'd1;
                if (noteEnd) noteOn <= 1'b0;
                if (tableEnd) index <= '0;
                else if (noteEnd) index <= index + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_synth_note_fetcher.sv
// tb_synth_note_fetcher: directed checks of three fetcher variants sharing one stimulus and table
module tb_synth_note_fetcher;
    logic        clk = 1'b0;
    logic        rst, clr, start, stop, loop, tick;
    logic [31:0] baseAddr;
    logic [31:0] mem [16];
    int          cyc = 0;
    int          tickDiv = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          s;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tickDiv = (tickDiv == 9) ? 0 : tickDiv + 1;
            tick = (tickDiv == 9);
        end
    end

    // u[0]: 256 notes, latency 1; u[1]: 4 notes, latency 1; u[2]: 256 notes, latency 2
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int LAT  = (g == 2) ? 2 : 1;
        localparam int MAXN = (g == 1) ? 4 : 256;
        synth_note_fetcher_if bus ();
        logic [31:0] pipe;
        int          doneCnt = 0, doneCyc = 0, rises = 0, tickCnt = 0, gapCnt = 0, gap = 0, wraps = 0;
        logic [31:0] maxAddr = 0, prevAddr = 0;
        logic        prevOn = 1'b0;
        logic [7:0]  pitchLog [8];
        logic [6:0]  volLog [8];
        int          tickLog [8];
        assign bus.iStart    = start;
        assign bus.iStop     = stop;
        assign bus.iLoop     = loop;
        assign bus.iTick     = tick;
        assign bus.iBaseAddr = baseAddr;
        assign bus.iSynthNoteData = (LAT == 2) ? pipe : mem[bus.oSynthAddress[5:2]];
        always @(posedge clk) pipe <= mem[bus.oSynthAddress[5:2]];
        synth_note_fetcher #(.MAX_NOTES(MAXN), .MEM_LATENCY(LAT)) dut (.iCLK(clk), .iRST(rst), .bus(bus));
        always @(negedge clk) begin
            prevOn   <= bus.oNoteOn;
            prevAddr <= bus.oSynthAddress;
            if (clr) begin
                doneCnt <= 0; doneCyc <= 0; rises <= 0; tickCnt <= 0;
                gapCnt <= 0; gap <= 0; wraps <= 0; maxAddr <= 0;
            end else begin
                if (bus.oDone) begin
                    doneCnt <= doneCnt + 1;
                    if (doneCnt == 0) doneCyc <= cyc;
                end
                if (bus.oNoteOn && !prevOn) begin
                    if (rises < 8) begin
                        pitchLog[rises] <= bus.oPitch;
                        volLog[rises]   <= bus.oVolume;
                    end
                    rises   <= rises + 1;
                    tickCnt <= tick ? 1 : 0;
                    gap     <= gapCnt;
                end else if (bus.oNoteOn && tick) tickCnt <= tickCnt + 1;
                if (!bus.oNoteOn && prevOn && rises > 0 && rises <= 8) tickLog[rises-1] <= tickCnt;
                gapCnt <= bus.oNoteOn ? 0 : gapCnt + 1;
                if (bus.oSynthAddress > maxAddr) maxAddr <= bus.oSynthAddress;
                if (bus.oSynthAddress == 32'h10010000 && prevAddr != 32'h10010000) wraps <= wraps + 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; baseAddr = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        step(3);
        check("rst_addr", u[0].bus.oSynthAddress, 32'h0);
        check("rst_pitch", u[0].bus.oPitch, 8'h0);
        check("rst_vol", u[0].bus.oVolume, 7'h0);
        check("rst_gate", u[0].bus.oNoteOn, 1'b0);
        check("rst_busy", u[0].bus.oBusy, 1'b0);
        check("rst_done", u[0].bus.oDone, 1'b0);
        rst = 1'b0; clr = 1'b0;
        step(2);
        check("idle_busy", u[0].bus.oBusy, 1'b0);

        // two notes then an end marker; base low bits must be ignored
        mem[0] = 32'h40450003; mem[1] = 32'h20480001; mem[2] = 32'h0;
        baseAddr = 32'h10010003;
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 0; i < 1000 && !(u[0].doneCnt > 0 && u[1].doneCnt > 0 && u[2].doneCnt > 0); i++) step(1);
        step(2);
        check("t1_rises", u[0].rises, 2);
        check("t1_pitch0", u[0].pitchLog[0], 8'h45);
        check("t1_vol0", u[0].volLog[0], 7'h40);
        check("t1_ticks0", u[0].tickLog[0], 3);
        check("t1_pitch1", u[0].pitchLog[1], 8'h48);
        check("t1_vol1", u[0].volLog[1], 7'h20);
        check("t1_ticks1", u[0].tickLog[1], 1);
        check("t1_done", u[0].doneCnt, 1);
        check("t1_gap", u[0].gap, 3);
        check("t1_gate_end", u[0].bus.oNoteOn, 1'b0);
        check("t1_busy_end", u[0].bus.oBusy, 1'b0);
        check("t1_pitch_hold", u[0].bus.oPitch, 8'h48);
        check("t6_pitch0", u[2].pitchLog[0], 8'h45);
        check("t6_pitch1", u[2].pitchLog[1], 8'h48);
        check("t6_ticks0", u[2].tickLog[0], 3);
        check("t6_gap", u[2].gap, 4);
        check("t6_done", u[2].doneCnt, 1);

        // empty table: no gate, done after latency+3 clocks
        clr = 1'b1; step(1); clr = 1'b0;
        mem[8] = 32'h0;
        baseAddr = 32'h10010020;
        start = 1'b1; s = cyc; step(1); start = 1'b0;
        step(10);
        check("t2_done_lat1", u[0].doneCyc - s, 4);
        check("t2_done_lat2", u[2].doneCyc - s, 5);
        check("t2_rises", u[0].rises, 0);
        check("t2_done_cnt", u[0].doneCnt, 1);

        // looping playback, then stop while a note sounds
        clr = 1'b1; step(1); clr = 1'b0;
        loop = 1'b1;
        baseAddr = 32'h10010000;
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 0; i < 3000 && u[0].wraps < 4; i++) step(1);
        check("t3_wraps", u[0].wraps, 4);
        for (int i = 0; i < 300 && !u[0].bus.oNoteOn; i++) step(1);
        check("t3_gate_before", u[0].bus.oNoteOn, 1'b1);
        stop = 1'b1; step(1);
        check("t3_stop_busy", u[0].bus.oBusy, 1'b0);
        check("t3_stop_gate", u[0].bus.oNoteOn, 1'b0);
        check("t3_stop_pitch", u[0].bus.oPitch, 8'h45);
        check("t3_stop_vol", u[0].bus.oVolume, 7'h40);
        stop = 1'b0; loop = 1'b0;
        step(5);
        check("t3_idle", u[0].bus.oBusy, 1'b0);
        check("t3_no_done", u[0].doneCnt, 0);
        check("t3_no_done_lat2", u[2].doneCnt, 0);
        check("t3_lat2_idle", u[2].bus.oBusy, 1'b0);

        // no marker within four notes: short variant stops at its last index
        clr = 1'b1; step(1); clr = 1'b0;
        mem[0] = 32'h10110001; mem[1] = 32'h10120001; mem[2] = 32'h10130001; mem[3] = 32'h10140001; mem[4] = 32'h0;
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 0; i < 1000 && !(u[0].doneCnt > 0 && u[1].doneCnt > 0); i++) step(1);
        step(2);
        check("t4_max_addr", u[1].maxAddr, 32'h1001000C);
        check("t4_done", u[1].doneCnt, 1);
        check("t4_rises", u[1].rises, 4);
        check("t4_pitch3", u[1].pitchLog[3], 8'h14);
        check("t4_ref_max_addr", u[0].maxAddr, 32'h10010010);
        check("t4_ref_rises", u[0].rises, 4);

        // reset mid-note, then simultaneous start and stop
        clr = 1'b1; step(1); clr = 1'b0;
        mem[0] = 32'h40450003; mem[1] = 32'h20480001; mem[2] = 32'h0; mem[3] = 32'h0;
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 0; i < 100 && !u[0].bus.oNoteOn; i++) step(1);
        check("t5_pitch_play", u[0].bus.oPitch, 8'h45);
        rst = 1'b1; step(1);
        check("t5_rst_pitch", u[0].bus.oPitch, 8'h0);
        check("t5_rst_vol", u[0].bus.oVolume, 7'h0);
        check("t5_rst_gate", u[0].bus.oNoteOn, 1'b0);
        check("t5_rst_busy", u[0].bus.oBusy, 1'b0);
        check("t5_rst_addr", u[0].bus.oSynthAddress, 32'h0);
        rst = 1'b0; start = 1'b1; stop = 1'b1; step(1);
        check("t5_startstop", u[0].bus.oBusy, 1'b0);
        start = 1'b0; stop = 1'b0;
        step(3);
        check("t5_still_idle", u[0].bus.oBusy, 1'b0);
        check("t5_no_done", u[0].doneCnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
